// File: rtl/addr_route_pkg.sv
// addr_route_pkg: shared defaults and helpers for addr_route_buffer
package addr_route_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DROP_CNT_W = 16;
  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/route_fifo.sv
// route_fifo: show-ahead FIFO, head forced to 0 while empty
module route_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LVL_W = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic pop_ok;
  assign empty = level == '0;
  assign full = level == LVL_W'(DEPTH);
  assign pop_ok = pop && !empty;
  assign dout = empty ? '0 : mem[rd];
  // storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop_ok) rd <= rd + 1'b1;
      level <= level + LVL_W'(push) - LVL_W'(pop_ok);
    end
endmodule

// File: rtl/addr_route_buffer.sv
// addr_route_buffer: decodes low address bits into per-port FIFOs, drops off-base words.
// Optional ROUTE_DROP_CNT_EN adds a saturating drop_cnt output.
module addr_route_buffer
  import addr_route_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                                    clk,
  input  logic                                    rst_b,
  input  logic [ADDR_W-1:0]                       addr_in,
  input  logic [DATA_W-1:0]                       data_in,
  input  logic                                    valid_in,
  output logic                                    rcv_rdy,
  output logic [NUM_PORTS*ADDR_W-1:0]             addr_out,
  output logic [NUM_PORTS*DATA_W-1:0]             data_out,
  output logic [NUM_PORTS-1:0]                    valid_out,
  input  logic [NUM_PORTS-1:0]                    data_rd,
  output logic [NUM_PORTS*($clog2(DEPTH)+1)-1:0]  fill_level
`ifdef ROUTE_DROP_CNT_EN
  , output logic [DROP_CNT_W-1:0]                 drop_cnt
`endif
);
  localparam int SEL_W = sel_w(NUM_PORTS);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
  logic [SEL_W-1:0] dest;
  logic match, acc;
  logic [NUM_PORTS-1:0] full, empty, push;
  entry_t din;
  assign dest = addr_in[SEL_W-1:0];
  assign match = addr_in[ADDR_W-1:SEL_W] == BASE_ADDR[ADDR_W-1:SEL_W];
  assign rcv_rdy = rst_b && (!match || !full[dest]);
  assign acc = valid_in && rcv_rdy;
  assign din = '{addr: addr_in, data: data_in};
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    entry_t dout;
    assign push[p] = acc && match && dest == SEL_W'(p);
    route_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst_b(rst_b),
      .push(push[p]),
      .pop(data_rd[p]),
      .din(din),
      .dout(dout),
      .full(full[p]),
      .empty(empty[p]),
      .level(fill_level[p*LVL_W +: LVL_W])
    );
    assign addr_out[p*ADDR_W +: ADDR_W] = dout.addr;
    assign data_out[p*DATA_W +: DATA_W] = dout.data;
    assign valid_out[p] = !empty[p];
  end
`ifdef ROUTE_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) drop_cnt <= '0;
    else if (acc && !match && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_addr_route_buffer.sv
// tb_addr_route_buffer: scoreboard bench for addr_route_buffer (default parameters)
module tb_addr_route_buffer;
  typedef struct {
    int p;
    logic [7:0] a;
    logic [7:0] d;
  } sb_t;
  logic clk = 0;
  logic rst_b;
  logic [7:0] addr_in, data_in;
  logic valid_in;
  logic rcv_rdy;
  logic [31:0] addr_out, data_out;
  logic [3:0] valid_out, data_rd;
  logic [11:0] fill_level;
  int n_chk = 0, n_ok = 0, drops = 0;
  sb_t sb[$];
`ifdef ROUTE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  addr_route_buffer dut (
    .clk(clk), .rst_b(rst_b), .addr_in(addr_in), .data_in(data_in), .valid_in(valid_in),
    .rcv_rdy(rcv_rdy), .addr_out(addr_out), .data_out(data_out), .valid_out(valid_out),
    .data_rd(data_rd), .fill_level(fill_level)
`ifdef ROUTE_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  function automatic int cnt(input int p);
    int c = 0;
    foreach (sb[i]) if (sb[i].p == p) c++;
    return c;
  endfunction
  function automatic logic match(input logic [7:0] a);
    return a[7:2] == 6'd0;
  endfunction
  // Checks model state, resolves pops/pushes for the coming edge, advances to next negedge.
  task automatic cyc();
    logic [3:0] ev;
    int idx;
    #1;
    for (int p = 0; p < 4; p++) begin
      ev[p] = cnt(p) != 0;
      chk($sformatf("lvl%0d", p), 32'(fill_level[p*3 +: 3]), 32'(cnt(p)));
    end
    chk("valid_out", 32'(valid_out), 32'(ev));
    chk("rcv_rdy", 32'(rcv_rdy), 32'(!match(addr_in) || cnt(int'(addr_in[1:0])) < 4));
    for (int p = 0; p < 4; p++)
      if (ev[p] && data_rd[p]) begin
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].p == p) idx = i;
        chk($sformatf("data%0d", p), 32'(data_out[p*8 +: 8]), 32'(sb[idx].d));
        chk($sformatf("addr%0d", p), 32'(addr_out[p*8 +: 8]), 32'(sb[idx].a));
        sb.delete(idx);
      end
    if (valid_in && rcv_rdy) begin
      if (match(addr_in)) sb.push_back('{int'(addr_in[1:0]), addr_in, data_in});
      else if (drops < 65535) drops++;
    end
    @(negedge clk);
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] d);
    addr_in = a;
    data_in = d;
    valid_in = 1;
    cyc();
    valid_in = 0;
  endtask
  initial begin
    rst_b = 0;
    valid_in = 1;
    addr_in = 8'h02;
    data_in = 8'h00;
    data_rd = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdy", 32'(rcv_rdy), 0);
    chk("rst_vo", 32'(valid_out), 0);
    chk("rst_fill", 32'(fill_level), 0);
    valid_in = 0;
    rst_b = 1;
    cyc();
    chk("rdy_after_rst", 32'(rcv_rdy), 1);
    send(8'h02, 8'hA5);
    #1;
    chk("single_vo", 32'(valid_out), 32'h4);
    chk("single_d", 32'(data_out[23:16]), 32'hA5);
    chk("single_a", 32'(addr_out[23:16]), 32'h02);
    data_rd = 4'b0100;
    cyc();
    data_rd = 0;
    cyc();
    chk("single_empty", 32'(valid_out[2]), 0);
    for (int i = 0; i < 4; i++) send(8'h01, 8'h11 + 8'(i));
    addr_in = 8'h01;
    #1;
    chk("full_lvl", 32'(fill_level[5:3]), 4);
    chk("full_rdy", 32'(rcv_rdy), 0);
    valid_in = 1;
    cyc();
    valid_in = 0;
    addr_in = 8'h03;
    #1;
    chk("other_rdy", 32'(rcv_rdy), 1);
    data_rd = 4'b0010;
    repeat (5) cyc();
    data_rd = 0;
    for (int i = 0; i < 3; i++) begin
      send(8'h15, 8'h77);
      chk("drop_vo", 32'(valid_out), 0);
`ifdef ROUTE_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(drops));
`endif
    end
    send(8'h00, 8'hAA);
    send(8'h00, 8'hBB);
    data_rd = 4'b0001;
    send(8'h00, 8'hCC);
    data_rd = 0;
    #1;
    chk("pp_lvl", 32'(fill_level[2:0]), 2);
    chk("pp_head", 32'(data_out[7:0]), 32'hBB);
    data_rd = 4'b0001;
    repeat (3) cyc();
    data_rd = 0;
    for (int i = 0; i < 3; i++) begin
      send(8'h00, 8'h30 + 8'(i));
      send(8'h03, 8'h40 + 8'(i));
    end
    #3;
    rst_b = 0;
    #1;
    chk("mrst_vo", 32'(valid_out), 0);
    chk("mrst_fill", 32'(fill_level), 0);
    chk("mrst_rdy", 32'(rcv_rdy), 0);
`ifdef ROUTE_DROP_CNT_EN
    chk("mrst_drop", 32'(drop_cnt), 0);
`endif
    sb.delete();
    drops = 0;
    @(negedge clk);
    rst_b = 1;
    send(8'h00, 8'h5A);
    #1;
    chk("post_lvl", 32'(fill_level[2:0]), 1);
    chk("post_d", 32'(data_out[7:0]), 32'h5A);
    for (int i = 0; i < 60; i++) begin
      addr_in = {5'd0, 1'($urandom_range(0, 3) == 0), 2'($urandom)};
      data_in = 8'($urandom);
      valid_in = 1'($urandom);
      data_rd = 4'($urandom);
      cyc();
    end
    valid_in = 0;
    data_rd = 4'hF;
    repeat (6) cyc();
`ifdef ROUTE_DROP_CNT_EN
    #1;
    chk("rand_drop", 32'(drop_cnt), 32'(drops));
`endif
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule

// File: doc/addr_route_buffer.md
Name: addr_route_buffer

Overview:
Parametrised successor to the single-channel downstream/upstream switch port. Accepts address/data words on one downstream valid/ready channel and decodes the low address bits to pick one of NUM_PORTS output channels. Each output channel has its own DEPTH-entry FIFO, drained through an upstream valid/data_rd handshake. Words whose upper address field does not match BASE_ADDR are accepted and discarded.

Parameters:
DATA_W, 8, data word width
ADDR_W, 8, address width; must exceed SEL_W
NUM_PORTS, 4, output channel count; power of 2, >=2
DEPTH, 4, entries per port FIFO; power of 2, >=2
BASE_ADDR, 8'h00, upper address field (bits ADDR_W-1:SEL_W) that must match for a word to be routed

Ports:
clk  in  1  clock, single clock domain
rst_b  in  1  reset, asynchronous, active-low
addr_in  in  ADDR_W  downstream address
data_in  in  DATA_W  downstream data
valid_in  in  1  downstream word valid
rcv_rdy  out  1  block can take the presented word
addr_out  out  NUM_PORTS*ADDR_W  per-port head address, port p at [p*ADDR_W +: ADDR_W]
data_out  out  NUM_PORTS*DATA_W  per-port head data, same packing
valid_out  out  NUM_PORTS  per-port head valid
data_rd  in  NUM_PORTS  per-port pop request from the sink
fill_level  out  NUM_PORTS*(LVL_W)  per-port occupancy, 0..DEPTH, with LVL_W = $clog2(DEPTH)+1

Behaviour:
- SEL_W = $clog2(NUM_PORTS). Destination port is dest = addr_in[SEL_W-1:0]. A word matches when addr_in[ADDR_W-1:SEL_W] == BASE_ADDR[ADDR_W-1:SEL_W].
- rcv_rdy is combinational:
  - 0 while rst_b = 0.
  - Otherwise 1 for a non-matching address.
  - Otherwise !full[dest].
  - rcv_rdy does not depend on valid_in or on same-cycle data_rd. A full port with a simultaneous pop still reports rcv_rdy = 0.
- Transfer occurs on a rising edge with valid_in && rcv_rdy.
  - Matching word: {addr_in, data_in} is written to FIFO[dest].
  - Non-matching word: discarded.
- Latency: a word accepted at edge k gives valid_out[dest] = 1 after edge k. No bypass when the FIFO is empty.
- valid_out[p] = (fill_level[p] != 0), taken from registered state. addr_out/data_out show the FIFO head (show-ahead) and are forced to 0 while valid_out[p] = 0.
- Pop occurs on an edge where valid_out[p] && data_rd[p]. data_rd[p] on an empty port is ignored.
- Simultaneous push and pop on the same non-full port: fill_level is unchanged and FIFO order is preserved.
- Ports operate independently. A full port blocks only input words addressed to it (head-of-line blocking at the input is accepted).
- Pointers wrap modulo DEPTH. fill_level never exceeds DEPTH and never goes below 0.
- Reset, at any time including mid-operation: all pointers and levels go to 0, valid_out = 0, addr_out/data_out = 0, fill_level = 0, rcv_rdy = 0. Storage arrays are not reset. In-flight words are lost.

Optional Feature:
- Macro ROUTE_DROP_CNT_EN.
- Defined: adds output drop_cnt[15:0].
  - Increments by 1 on every accepted non-matching word.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port is absent and no counter logic exists. Discard behaviour is identical in both builds.

Decomposition:
- Package addr_route_pkg holds:
  - default constants (DATA_W, ADDR_W, NUM_PORTS, DEPTH defaults);
  - function sel_w(n) returning $clog2(n);
  - DROP_CNT_W = 16.
- Entry typedef {addr, data} depends on parameters and is declared locally.
- Sub-module route_fifo:
  - single-port show-ahead FIFO with push, pop, full, empty, level;
  - instantiated NUM_PORTS times in a generate loop.
- Top level holds the decode, rcv_rdy logic, output packing and the optional counter.

Test Plan:
1. Reset: assert rst_b = 0 with valid_in = 1 -> rcv_rdy = 0, valid_out = 4'b0000, fill_level all 0. Release -> rcv_rdy = 1 next cycle.
2. Single route: addr_in = 8'h02, data_in = 8'hA5 for one cycle -> after the edge valid_out = 4'b0100, port 2 data_out = 8'hA5 and addr_out = 8'h02. data_rd[2] = 1 for one edge -> valid_out[2] = 0, fill_level[2] = 0.
3. Full: write 4 words 8'h11..8'h14 to addr 8'h01 -> fill_level[1] = 4. With addr_in = 8'h01, rcv_rdy = 0. Switch to addr_in = 8'h03 -> rcv_rdy = 1. Drain port 1 -> reads 11, 12, 13, 14 in order.
4. Drop: addr_in = 8'h15 (upper field 5 != 0) -> rcv_rdy = 1, no valid_out change. With ROUTE_DROP_CNT_EN, drop_cnt goes 0 -> 1. Repeat 3 times -> drop_cnt = 3.
5. Concurrent push and pop: port 0 level 2 (8'hAA, 8'hBB). Push 8'hCC with data_rd[0] = 1 -> level stays 2, head becomes 8'hBB, then 8'hCC.
6. Reset mid-operation: ports 0 and 3 hold 3 words each, pull rst_b low asynchronously mid-cycle -> valid_out and fill_level go 0 immediately. After release, first push to port 0 reads back correctly with level 1.
